mips_branch_resolve: RTL

- Execute-stage counterpart to the fetch-stage branch predictor.
- Carries each fetched instruction's prediction metadata down the IF→ID→EX pipe.
- Compares the prediction against the actual outcome and target resolved in EX.
- On a misprediction, issues a one-cycle PC redirect plus pipeline flush, and always drives a predictor/BTB update record for every resolved control-flow instruction.

---
 rtl/mips_br_pkg.sv | 26 ++
 rtl/mips_br_meta_pipe.sv | 32 +++
 rtl/mips_branch_resolve.sv | 115 +++++++++++
 3 files changed

// File: rtl/mips_br_pkg.sv
// Shared types for the execute-stage branch resolver: the per-instruction
// prediction metadata record, the resolver state and the PC width.
package mips_br_pkg;

    localparam int ADDR_W = 30;

    typedef struct packed {
        logic              valid;
        logic              is_cf;
        logic [ADDR_W-1:0] pc;
        logic              pred_taken;
        logic [ADDR_W-1:0] pred_target;
    } br_meta_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } br_state_t;

    // Sequential fetch address after a branch and its delay slot(s), mod 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] fall_through(input logic [ADDR_W-1:0] pc,
                                                       input int delay_slot);
        return pc + ADDR_W'(1 + delay_slot);
    endfunction

endpackage

// File: rtl/mips_br_meta_pipe.sv
// Two-stage (ID, EX) metadata register pipe. Holds on stall; clear_i drops
// both valid bits and takes priority over advance_i.
module mips_br_meta_pipe
    import mips_br_pkg::*;
(
    input  logic     clk,
    input  logic     rst_b,
    input  logic     advance_i,
    input  logic     clear_i,
    input  br_meta_t if_meta_i,
    output br_meta_t ex_meta_o
);

    br_meta_t id_q;
    br_meta_t ex_q;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            id_q <= '0;
            ex_q <= '0;
        end else if (clear_i) begin
            id_q.valid <= 1'b0;
            ex_q.valid <= 1'b0;
        end else if (advance_i) begin
            id_q <= if_meta_i;
            ex_q <= id_q;
        end
    end

    assign ex_meta_o = ex_q;

endmodule

// File: rtl/mips_branch_resolve.sv
// Execute-stage branch resolution: compares prediction metadata with the
// actual outcome, emits update records and a one-cycle redirect/flush.
// Optional saturating statistics counters are enabled by MIPS_BR_STATS_EN.
module mips_branch_resolve
    import mips_br_pkg::*;
#(
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              stall,
    input  logic              if_valid,
    input  logic              if_is_cf,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic              if_pred_taken,
    input  logic [ADDR_W-1:0] if_pred_target,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_target,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic              upd_valid,
    output logic [ADDR_W-1:0] upd_pc,
    output logic              upd_taken,
    output logic [ADDR_W-1:0] upd_target,
    output logic              upd_mispred,
    output logic [CNT_W-1:0]  stat_branches,
    output logic [CNT_W-1:0]  stat_mispred
);

    br_state_t state_q;
    br_meta_t  if_meta;
    br_meta_t  ex_meta;
    logic      advance;
    logic      resolve;
    logic      mispred;

    assign if_meta = '{valid: if_valid, is_cf: if_is_cf, pc: if_pc,
                       pred_taken: if_pred_taken, pred_target: if_pred_target};

    assign advance = (state_q == IDLE) && !stall;
    assign resolve = advance && ex_meta.valid && ex_meta.is_cf;
    assign mispred = (ex_meta.pred_taken != ex_taken) ||
                     (ex_meta.pred_taken && ex_taken && (ex_meta.pred_target != ex_target));

    mips_br_meta_pipe u_pipe (
        .clk       (clk),
        .rst_b     (rst_b),
        .advance_i (advance),
        .clear_i   (state_q == FLUSH),
        .if_meta_i (if_meta),
        .ex_meta_o (ex_meta)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q        <= IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            upd_valid      <= 1'b0;
            upd_pc         <= '0;
            upd_taken      <= 1'b0;
            upd_target     <= '0;
            upd_mispred    <= 1'b0;
        end else begin
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            upd_valid      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (resolve) begin
                        upd_valid   <= 1'b1;
                        upd_pc      <= ex_meta.pc;
                        upd_taken   <= ex_taken;
                        upd_target  <= ex_target;
                        upd_mispred <= mispred;
                        if (mispred) begin
                            redirect_valid <= 1'b1;
                            flush          <= 1'b1;
                            redirect_pc    <= ex_taken ? ex_target
                                                       : fall_through(ex_meta.pc, DELAY_SLOT);
                            state_q        <= FLUSH;
                        end
                    end
                end
                FLUSH:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MIPS_BR_STATS_EN
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] mp_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else if (resolve) begin
            if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + 1'b1;
            if (mispred && (mp_cnt_q != '1)) mp_cnt_q <= mp_cnt_q + 1'b1;
        end
    end

    assign stat_branches = br_cnt_q;
    assign stat_mispred  = mp_cnt_q;
`else
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif

endmodule
